// File: rtl/wb_dmem_if.sv
// Data-memory bus between the writeback stage and data memory.
// Word-wide req/gnt/rvalid handshake; the stage is the master.
interface wb_dmem_if #(
    parameter int DATA_W = 32
);
    logic              DMemReq;
    logic              DMemWe;
    logic [DATA_W-1:0] DMemAddr;
    logic [DATA_W-1:0] DMemWData;
    logic              DMemGnt;
    logic              DMemRValid;
    logic [DATA_W-1:0] DMemRData;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemWData,
        input  DMemGnt, DMemRValid, DMemRData
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemWData,
        output DMemGnt, DMemRValid, DMemRData
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: finishes the popcount tree, runs word loads/stores on the
// data-memory bus, selects the RF writeback value and stalls the pipe while a
// memory access is outstanding.
// Optional macro POPCNT_ACC_EN adds a saturating 16-bit popcount accumulator.
module wb_stage #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        A3_W,
    input  logic [DATA_W-1:0] RD2_W,
    input  logic [DATA_W-1:0] ALUResultW,
    input  logic [DATA_W-1:0] PCNextW,
    input  logic [2:0]        popcnt_lvl2_W [7:0],
    input  logic              RegWriteW,
    input  logic              MemReadW,
    input  logic              MemWriteW,
    input  logic [1:0]        ResultSrcW,
    wb_dmem_if.master         dmem,
    output logic              WE3,
    output logic [4:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              StallReqW,
    output logic              MisalignW,
    output logic              BusErrW,
    output logic [5:0]        PopcntW
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Wide enough to hold TIMEOUT_CYC itself (and at least one bit when it is 0).
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              errflag_reg;
    logic [DATA_W-1:0] load_data_reg;

    logic              mem_op, misaligned, tmo;
    logic              req, stall, misalign, buserr, we3_raw;
    logic [DATA_W-1:0] pop_wd, result;
    logic [5:0]        psum [8:0];

    // Final popcount level: running sum of the eight partial counts (max 32).
    assign psum[0] = 6'd0;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pop
            assign psum[gi+1] = psum[gi] + {3'b000, popcnt_lvl2_W[gi]};
        end
    endgenerate
    assign PopcntW = psum[8];

    assign mem_op     = MemReadW | MemWriteW;
    assign misaligned = mem_op & (ALUResultW[1:0] != 2'b00);
    assign tmo        = (TIMEOUT_CYC != 0) && (cnt_reg == CNT_W'(TIMEOUT_CYC));

`ifdef POPCNT_ACC_EN
    logic [15:0] acc_reg, acc_next;
    logic [16:0] acc_sum;
    logic        acc_upd;

    assign acc_sum = {1'b0, acc_reg} + {11'd0, PopcntW};
    assign acc_upd = (state_reg == S_IDLE) && !mem_op && (ResultSrcW == 2'b11);

    // Writing a popcount to x0 is the accumulator clear; otherwise saturating add.
    always_comb begin
        if (RegWriteW && (A3_W == 5'd0))
            acc_next = 16'h0000;
        else if (acc_sum[16])
            acc_next = 16'hFFFF;
        else
            acc_next = acc_sum[15:0];
    end

    // Accumulator advances once per popcount instruction retiring in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_reg <= 16'h0000;
        else if (acc_upd)
            acc_reg <= acc_next;
    end

    assign pop_wd = {{(DATA_W-16){1'b0}}, acc_next};
`else
    assign pop_wd = {{(DATA_W-6){1'b0}}, PopcntW};
`endif

    // Writeback source select.
    always_comb begin
        case (ResultSrcW)
            2'b00:   result = ALUResultW;
            2'b01:   result = load_data_reg;
            2'b10:   result = PCNextW;
            default: result = pop_wd;
        endcase
    end

    // Next-state and per-state control; timeout wins over gnt/rvalid.
    always_comb begin
        state_next = state_reg;
        req        = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        buserr     = 1'b0;
        we3_raw    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!mem_op) begin
                    we3_raw = RegWriteW;
                end else if (misaligned) begin
                    misalign = 1'b1;
                end else begin
                    stall      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (tmo) begin
                    buserr     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    req = 1'b1;
                    if (dmem.DMemGnt)
                        state_next = MemWriteW ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                stall = 1'b1;
                if (tmo) begin
                    buserr     = 1'b1;
                    state_next = S_DONE;
                end else if (dmem.DMemRValid) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                we3_raw    = RegWriteW & MemReadW & ~errflag_reg;
                state_next = S_IDLE;
            end
        endcase
    end

    // State, timeout counter, error flag and captured load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            errflag_reg   <= 1'b0;
            load_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE)
                cnt_reg <= '0;
            else if ((state_reg == S_REQ) || (state_reg == S_RESP))
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (buserr)
                errflag_reg <= 1'b1;
            else if (state_reg == S_DONE)
                errflag_reg <= 1'b0;
            if ((state_reg == S_RESP) && !tmo && dmem.DMemRValid)
                load_data_reg <= dmem.DMemRData;
        end
    end

    // Outputs are forced low while reset is held; x0 is never written.
    assign dmem.DMemReq   = req & ~reset;
    assign dmem.DMemWe    = req & MemWriteW & ~reset;
    assign dmem.DMemAddr  = (req && !reset) ? {ALUResultW[DATA_W-1:2], 2'b00} : '0;
    assign dmem.DMemWData = (req && !reset) ? RD2_W : '0;
    assign WE3       = we3_raw & (A3_W != 5'd0) & ~reset;
    assign A3        = reset ? 5'd0 : A3_W;
    assign WD3       = reset ? '0 : result;
    assign StallReqW = stall & ~reset;
    assign MisalignW = misalign & ~reset;
    assign BusErrW   = buserr & ~reset;
endmodule

// File: tb/tb_wb_stage.sv
// Directed + randomized bench for wb_stage against a transaction-level model
// (word memory scoreboard, last-load register, popcount/accumulator arithmetic).
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]  A3_W;
    logic [31:0] RD2_W, ALUResultW, PCNextW;
    logic [2:0]  pops [7:0];
    logic        RegWriteW, MemReadW, MemWriteW;
    logic [1:0]  ResultSrcW;

    logic        WE3, StallReqW, MisalignW, BusErrW;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [5:0]  PopcntW;
    logic        WE3_b, StallReqW_b, MisalignW_b, BusErrW_b;
    logic [4:0]  A3_b;
    logic [31:0] WD3_b;
    logic [5:0]  PopcntW_b;

    wb_dmem_if #(.DATA_W(32)) bus ();
    wb_dmem_if #(.DATA_W(32)) bus2 ();

    wb_stage #(.DATA_W(32), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .A3_W(A3_W), .RD2_W(RD2_W), .ALUResultW(ALUResultW),
        .PCNextW(PCNextW), .popcnt_lvl2_W(pops), .RegWriteW(RegWriteW), .MemReadW(MemReadW),
        .MemWriteW(MemWriteW), .ResultSrcW(ResultSrcW), .dmem(bus), .WE3(WE3), .A3(A3),
        .WD3(WD3), .StallReqW(StallReqW), .MisalignW(MisalignW), .BusErrW(BusErrW),
        .PopcntW(PopcntW)
    );

    wb_stage #(.DATA_W(32), .TIMEOUT_CYC(4)) dut_tmo (
        .clk(clk), .reset(reset), .A3_W(A3_W), .RD2_W(RD2_W), .ALUResultW(ALUResultW),
        .PCNextW(PCNextW), .popcnt_lvl2_W(pops), .RegWriteW(RegWriteW), .MemReadW(MemReadW),
        .MemWriteW(MemWriteW), .ResultSrcW(ResultSrcW), .dmem(bus2), .WE3(WE3_b), .A3(A3_b),
        .WD3(WD3_b), .StallReqW(StallReqW_b), .MisalignW(MisalignW_b), .BusErrW(BusErrW_b),
        .PopcntW(PopcntW_b)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_load = 32'h0;
    int          acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pop_sum();
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(pops[i]);
        return s;
    endfunction

    task automatic set_pops(input bit all4);
        for (int i = 0; i < 8; i++) pops[i] = all4 ? 3'd4 : 3'($urandom_range(0, 4));
    endtask

    task automatic model_reset();
        last_load = 32'h0;
        acc       = 0;
    endtask

    // Non-memory instruction: result visible in the same cycle.
    task automatic run_op(input bit rw, input logic [4:0] ra3, input logic [1:0] src,
                          input logic [31:0] alu, input logic [31:0] pc);
        logic [31:0] exp_wd;
        int pop;
        RegWriteW = rw; A3_W = ra3; ResultSrcW = src; ALUResultW = alu; PCNextW = pc;
        MemReadW = 1'b0; MemWriteW = 1'b0; RD2_W = $urandom;
        pop = pop_sum();
        case (src)
            2'b00: exp_wd = alu;
            2'b01: exp_wd = last_load;
            2'b10: exp_wd = pc;
            default: begin
`ifdef POPCNT_ACC_EN
                if (rw && ra3 == 5'd0) acc = 0;
                else acc = (acc + pop > 65535) ? 65535 : acc + pop;
                exp_wd = 32'(acc);
`else
                exp_wd = 32'(pop);
`endif
            end
        endcase
        @(negedge clk);
        $display("[TB] op rw=%0d a3=%0d src=%0d wd3=%0h", rw, ra3, src, WD3);
        chk("op_we3", 32'(WE3), 32'(rw && ra3 != 5'd0));
        chk("op_a3", 32'(A3), 32'(ra3));
        chk("op_wd3", WD3, exp_wd);
        chk("op_popcnt", 32'(PopcntW), 32'(pop));
        chk("op_stall", 32'(StallReqW), 32'd0);
        chk("op_misalign", 32'(MisalignW), 32'd0);
        chk("op_req", 32'(bus.DMemReq), 32'd0);
        tick();
    endtask

    // Aligned load/store: gnt in REQ cycle g (0-based), rvalid in RESP cycle r (1-based).
    task automatic run_mem(input bit is_load, input bit rw, input logic [4:0] ra3,
                           input logic [1:0] src, input logic [31:0] addr,
                           input logic [31:0] wd, input int g, input int r);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        if (is_load && !mem.exists(waddr)) mem[waddr] = $urandom;
        RegWriteW = rw; A3_W = ra3; ResultSrcW = src; ALUResultW = addr; RD2_W = wd;
        MemReadW = is_load; MemWriteW = !is_load; PCNextW = $urandom;
        bus.DMemGnt = 1'b0; bus.DMemRValid = 1'b0;
        @(negedge clk);
        chk("mem_idle_stall", 32'(StallReqW), 32'd1);
        chk("mem_idle_req", 32'(bus.DMemReq), 32'd0);
        chk("mem_idle_we3", 32'(WE3), 32'd0);
        tick();
        for (int i = 0; i <= g; i++) begin
            bus.DMemGnt    = (i == g);
            bus.DMemRValid = (i == g) && is_load && (g % 2 == 1);
            bus.DMemRData  = $urandom;
            @(negedge clk);
            chk("mem_req", 32'(bus.DMemReq), 32'd1);
            chk("mem_we", 32'(bus.DMemWe), 32'(!is_load));
            chk("mem_addr", bus.DMemAddr, waddr);
            chk("mem_wdata", bus.DMemWData, wd);
            chk("mem_req_stall", 32'(StallReqW), 32'd1);
            tick();
        end
        bus.DMemGnt = 1'b0; bus.DMemRValid = 1'b0;
        if (is_load) begin
            for (int j = 1; j <= r; j++) begin
                bus.DMemRValid = (j == r);
                bus.DMemRData  = (j == r) ? mem[waddr] : $urandom;
                @(negedge clk);
                chk("mem_resp_req", 32'(bus.DMemReq), 32'd0);
                chk("mem_resp_stall", 32'(StallReqW), 32'd1);
                tick();
            end
            bus.DMemRValid = 1'b0;
            last_load = mem[waddr];
        end
        @(negedge clk);
        $display("[TB] %s addr=%0h g=%0d r=%0d we3=%0d wd3=%0h", is_load ? "load" : "store",
                 addr, g, r, WE3, WD3);
        chk("mem_done_stall", 32'(StallReqW), 32'd0);
        chk("mem_done_req", 32'(bus.DMemReq), 32'd0);
        chk("mem_done_we3", 32'(WE3), 32'(is_load && rw && ra3 != 5'd0));
        if (is_load) chk("mem_done_wd3", WD3, mem[waddr]);
        else mem[waddr] = wd;
        tick();
    endtask

    task automatic run_misaligned(input logic [31:0] addr, input bit is_load);
        RegWriteW = 1'b1; A3_W = 5'd7; ResultSrcW = 2'b01; ALUResultW = addr;
        MemReadW = is_load; MemWriteW = !is_load; RD2_W = $urandom;
        @(negedge clk);
        $display("[TB] misaligned addr=%0h misalign=%0d", addr, MisalignW);
        chk("mis_pulse", 32'(MisalignW), 32'd1);
        chk("mis_req", 32'(bus.DMemReq), 32'd0);
        chk("mis_stall", 32'(StallReqW), 32'd0);
        chk("mis_we3", 32'(WE3), 32'd0);
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        bit done_seen, err_prev;
        reset = 1'b1;
        RegWriteW = 1'b1; A3_W = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'h1236;
        PCNextW = 32'h44; RD2_W = 32'hFFFF_FFFF; MemReadW = 1'b1; MemWriteW = 1'b0;
        set_pops(1'b0);
        bus.DMemGnt = 1'b0; bus.DMemRValid = 1'b0; bus.DMemRData = 32'h0;
        bus2.DMemGnt = 1'b0; bus2.DMemRValid = 1'b0; bus2.DMemRData = 32'h0;
        #3;
        $display("[TB] reset state check");
        chk("rst_we3", 32'(WE3), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd3", WD3, 32'd0);
        chk("rst_stall", 32'(StallReqW), 32'd0);
        chk("rst_misalign", 32'(MisalignW), 32'd0);
        chk("rst_buserr", 32'(BusErrW), 32'd0);
        chk("rst_req", 32'(bus.DMemReq), 32'd0);
        chk("rst_addr", bus.DMemAddr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases.
        run_op(1'b1, 5'd5, 2'b00, 32'h1234, 32'h8);
        set_pops(1'b1);
        run_op(1'b1, 5'd6, 2'b11, 32'h0, 32'h8);
        run_op(1'b1, 5'd6, 2'b11, 32'h0, 32'h8);
        mem[32'h100] = 32'hDEADBEEF;
        run_mem(1'b1, 1'b1, 5'd10, 2'b01, 32'h100, 32'h0, 2, 3);
        run_op(1'b1, 5'd11, 2'b01, 32'h0, 32'h0);
        run_mem(1'b0, 1'b1, 5'd12, 2'b00, 32'h204, 32'hA5A5A5A5, 0, 1);
        run_misaligned(32'h102, 1'b1);
        run_op(1'b1, 5'd0, 2'b10, 32'h0, 32'h1000);
        run_misaligned(32'h207, 1'b0);
        run_mem(1'b1, 1'b1, 5'd13, 2'b01, 32'h204, 32'h0, 1, 1);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            set_pops(1'b0);
            case (kind)
                0, 1: run_op(1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom);
                2:    run_mem(1'b1, 1'($urandom), 5'($urandom), 2'b01,
                              {24'h0, 6'($urandom_range(0, 15)), 2'b00}, $urandom,
                              $urandom_range(0, 3), $urandom_range(1, 3));
                3:    run_mem(1'b0, 1'($urandom), 5'($urandom), 2'($urandom),
                              {24'h0, 6'($urandom_range(0, 15)), 2'b00}, $urandom,
                              $urandom_range(0, 3), 1);
                4:    run_misaligned({24'h0, 6'($urandom), 2'($urandom_range(1, 3))}, 1'($urandom));
                default: run_op(1'b1, 5'($urandom_range(1, 31)), 2'b11, $urandom, $urandom);
            endcase
        end

        // Bus timeout on the TIMEOUT_CYC = 4 instance: gnt given, rvalid never comes.
        pulse_reset();
        RegWriteW = 1'b1; A3_W = 5'd9; ResultSrcW = 2'b01; ALUResultW = 32'h300;
        MemReadW = 1'b1; MemWriteW = 1'b0;
        errs = 0; done_seen = 1'b0; err_prev = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            bus2.DMemGnt = (c == 1);
            @(negedge clk);
            if (err_prev) begin
                chk("tmo_done_we3", 32'(WE3_b), 32'd0);
                chk("tmo_done_stall", 32'(StallReqW_b), 32'd0);
                done_seen = 1'b1;
            end
            if (BusErrW_b) begin
                errs++;
                chk("tmo_err_req", 32'(bus2.DMemReq), 32'd0);
            end
            err_prev = BusErrW_b;
            tick();
        end
        bus2.DMemGnt = 1'b0;
        $display("[TB] timeout buserr_pulses=%0d done=%0d", errs, done_seen);
        chk("tmo_buserr_count", 32'(errs), 32'd1);
        chk("tmo_done_reached", 32'(done_seen), 32'd1);
        MemReadW = 1'b0; RegWriteW = 1'b0;
        @(negedge clk);
        chk("tmo_idle_stall", 32'(StallReqW_b), 32'd0);
        chk("tmo_idle_buserr", 32'(BusErrW_b), 32'd0);
        chk("tmo_idle_req", 32'(bus2.DMemReq), 32'd0);
        tick();

        // Reset while REQ is active: request drops at once.
        pulse_reset();
        RegWriteW = 1'b1; A3_W = 5'd3; ResultSrcW = 2'b01; ALUResultW = 32'h104;
        MemReadW = 1'b1; MemWriteW = 1'b0; bus.DMemGnt = 1'b0;
        @(negedge clk); tick();
        @(negedge clk);
        chk("rstreq_req_before", 32'(bus.DMemReq), 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset in REQ req=%0d stall=%0d", bus.DMemReq, StallReqW);
        chk("rstreq_req_drop", 32'(bus.DMemReq), 32'd0);
        chk("rstreq_stall_drop", 32'(StallReqW), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rstreq_back_idle_req", 32'(bus.DMemReq), 32'd0);
        chk("rstreq_back_idle_stall", 32'(StallReqW), 32'd1);
        tick();
        bus.DMemGnt = 1'b1;
        @(negedge clk); tick();
        bus.DMemGnt = 1'b0;
        @(negedge clk);
        chk("rstresp_stall_before", 32'(StallReqW), 32'd1);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset in RESP req=%0d stall=%0d", bus.DMemReq, StallReqW);
        chk("rstresp_stall_drop", 32'(StallReqW), 32'd0);
        chk("rstresp_req_drop", 32'(bus.DMemReq), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        run_op(1'b1, 5'd4, 2'b00, 32'hCAFE0001, 32'h0);
        run_op(1'b1, 5'd4, 2'b01, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
